add_seq_arb: RTL and testbench

Multi-word add sequencer and two-port arbiter. It time-shares one 16-bit ripple-carry adder slice (the existing `sixteen` block, instantiated once) between two requesters. Each accepted request adds two (16·WORDS)-bit operands least-significant slice first, one slice per clock, and chains the carry through a register. The block sits between the two datapath clients and the shared adder; it provides the arbitration, operand capture, slice sequencing and result return.

---
 rtl/add_seq_arb.sv | 181 ++++++++++++++++++
 tb/tb_add_seq_arb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_seq_arb.sv
// add_seq_arb: multi-word add sequencer with a two-port round-robin arbiter.
// One 16-bit ripple-carry slice (sixteen) is time-shared. Each accepted request
// adds two 16*WORDS-bit operands LS slice first, one slice per clock, with the
// carry chained through a register.
//
// Parameters:
//   WORDS          16-bit slices per operation (1..16)
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req0/1         requests (held until matching gnt)
//   a0/b0/a1/b1    operands (16*WORDS bits), cin0/1 carry-in
//   sub0/1         subtract select (only with ADDSEQ_SUB_EN defined)
//   gnt0/1         one-cycle acceptance pulse
//   busy           operation in progress
//   done, done_id  one-cycle completion pulse and owning requester
//   sum, cout      result and top-slice carry-out, held until next done
// Build option:
//   ADDSEQ_SUB_EN  enables subtraction (B inverted, carry-in forced to 1)

module sixteen (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);
   logic c;

   always_comb begin
      c   = cin;
      sum = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end
endmodule

module add_seq_arb #(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  req1,
   input  logic [16*WORDS-1:0]   a0,
   input  logic [16*WORDS-1:0]   b0,
   input  logic [16*WORDS-1:0]   a1,
   input  logic [16*WORDS-1:0]   b1,
   input  logic                  cin0,
   input  logic                  cin1,
   input  logic                  sub0,
   input  logic                  sub1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  busy,
   output logic                  done,
   output logic                  done_id,
   output logic [16*WORDS-1:0]   sum,
   output logic                  cout
);
   localparam int W  = 16 * WORDS;
   localparam int KW = 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic [KW-1:0] k;
   logic [W-1:0]  op_a, op_b, acc, acc_next;
   logic          carry, owner, last_id;
   logic [15:0]   sl_a, sl_b, sl_sum;
   logic          sl_cout;
   logic          any_req, pick1, last_slice;
   logic [W-1:0]  b_in0, b_in1;
   logic          cin_eff0, cin_eff1;

`ifdef ADDSEQ_SUB_EN
   assign b_in0    = sub0 ? ~b0 : b0;
   assign b_in1    = sub1 ? ~b1 : b1;
   assign cin_eff0 = sub0 | cin0;
   assign cin_eff1 = sub1 | cin1;
`else
   logic unused_sub;
   assign unused_sub = sub0 ^ sub1;
   assign b_in0      = b0;
   assign b_in1      = b1;
   assign cin_eff0   = cin0;
   assign cin_eff1   = cin1;
`endif

   always_comb begin
      any_req    = req0 | req1;
      // requester 1 wins if alone, or if both request and 0 was granted last
      pick1      = req1 & (~req0 | ~last_id);
      last_slice = (k == KW'(WORDS - 1));
      sl_a       = '0;
      sl_b       = '0;
      for (int unsigned i = 0; i < WORDS; i++) begin
         if (k == KW'(i)) begin
            sl_a = op_a[i*16 +: 16];
            sl_b = op_b[i*16 +: 16];
         end
      end
   end

   always_comb begin
      acc_next = acc;
      for (int unsigned i = 0; i < WORDS; i++) begin
         if (k == KW'(i)) acc_next[i*16 +: 16] = sl_sum;
      end
   end

   // cin is loaded into the carry register at capture, so the k=0 slice
   // sees it through the same path as the inter-slice carry
   sixteen u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (carry),
      .sum  (sl_sum),
      .cout (sl_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         k       <= '0;
         op_a    <= '0;
         op_b    <= '0;
         acc     <= '0;
         carry   <= 1'b0;
         owner   <= 1'b0;
         last_id <= 1'b1;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         done_id <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
         done <= 1'b0;
         case (state)
            S_RUN: begin
               acc   <= acc_next;
               carry <= sl_cout;
               k     <= k + KW'(1);
               if (last_slice) begin
                  state   <= S_DONE;
                  k       <= '0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  done_id <= owner;
                  sum     <= acc_next;
                  cout    <= sl_cout;
               end
            end
            default: begin
               if (any_req) begin
                  state   <= S_RUN;
                  k       <= '0;
                  busy    <= 1'b1;
                  owner   <= pick1;
                  last_id <= pick1;
                  gnt0    <= ~pick1;
                  gnt1    <= pick1;
                  op_a    <= pick1 ? a1 : a0;
                  op_b    <= pick1 ? b_in1 : b_in0;
                  carry   <= pick1 ? cin_eff1 : cin_eff0;
               end else begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_add_seq_arb.sv
module tb_add_seq_arb;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // WORDS=4 instance
   logic        req0, req1, cin0, cin1, sub0, sub1;
   logic [63:0] a0, b0, a1, b1;
   logic        gnt0, gnt1, busy, done, done_id, cout;
   logic [63:0] sum;

   // WORDS=1 instance
   logic        s_req0, s_req1, s_cin0, s_cin1, s_sub0, s_sub1;
   logic [15:0] s_a0, s_b0, s_a1, s_b1;
   logic        s_gnt0, s_gnt1, s_busy, s_done, s_done_id, s_cout;
   logic [15:0] s_sum;

   int checks = 0;
   int errors = 0;

   add_seq_arb #(.WORDS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .cin0(cin0), .cin1(cin1),
      .sub0(sub0), .sub1(sub1), .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
      .done(done), .done_id(done_id), .sum(sum), .cout(cout)
   );

   add_seq_arb #(.WORDS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req0(s_req0), .req1(s_req1),
      .a0(s_a0), .b0(s_b0), .a1(s_a1), .b1(s_b1), .cin0(s_cin0), .cin1(s_cin1),
      .sub0(s_sub0), .sub1(s_sub1), .gnt0(s_gnt0), .gnt1(s_gnt1), .busy(s_busy),
      .done(s_done), .done_id(s_done_id), .sum(s_sum), .cout(s_cout)
   );

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: full-width arithmetic; bit 16*w is the carry-out.
   function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                           input logic ci, input logic s, input int w);
      logic [64:0] m;
      m = (65'd1 << (16 * w)) - 65'd1;
      if (s) return ({1'b0, a} & m) + ({1'b0, ~b} & m) + 65'd1;
      else   return ({1'b0, a} & m) + ({1'b0, b} & m) + {64'd0, ci};
   endfunction

   function automatic logic rnd_sub();
`ifdef ADDSEQ_SUB_EN
      return 1'($urandom_range(0, 1));
`else
      return 1'b0;
`endif
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; s_req0 = 1'b0; s_req1 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic op4(input logic id, input logic [63:0] a, input logic [63:0] b,
                      input logic ci, input logic s);
      logic [64:0] e;
      int n, nbusy, extra;
      logic got;
      e = ref_add(a, b, ci, s, 4);
      @(negedge clk);
      if (id) begin a1 = a; b1 = b; cin1 = ci; sub1 = s; req1 = 1'b1; end
      else    begin a0 = a; b0 = b; cin0 = ci; sub0 = s; req0 = 1'b1; end
      n = 0; got = 1'b0;
      while (!got && n < 10) begin
         @(negedge clk); n++;
         got = id ? gnt1 : gnt0;
      end
      chk("gnt_latency", 65'(n), 65'd1);
      chk("gnt_other", {64'd0, id ? gnt0 : gnt1}, 65'd0);
      chk("busy_at_gnt", {64'd0, busy}, 65'd1);
      req0 = 1'b0; req1 = 1'b0;
      n = 0; got = 1'b0; nbusy = 1; extra = 0;
      while (!got && n < 40) begin
         @(negedge clk); n++;
         got = done;
         if (busy) nbusy++;
         if (gnt0 | gnt1) extra++;
      end
      chk("done_latency", 65'(n), 65'd4);
      chk("busy_cycles", 65'(nbusy), 65'd4);
      chk("gnt_pulse", 65'(extra), 65'd0);
      chk("busy_in_done", {64'd0, busy}, 65'd0);
      chk("done_id", {64'd0, done_id}, {64'd0, id});
      chk("sum", {1'b0, sum}, {1'b0, e[63:0]});
      chk("cout", {64'd0, cout}, {64'd0, e[64]});
      @(negedge clk);
      chk("done_pulse", {64'd0, done}, 65'd0);
      chk("sum_hold", {1'b0, sum}, {1'b0, e[63:0]});
   endtask

   task automatic op1(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic s);
      logic [64:0] e;
      int n;
      e = ref_add({48'd0, a}, {48'd0, b}, ci, s, 1);
      @(negedge clk);
      s_a0 = a; s_b0 = b; s_cin0 = ci; s_sub0 = s; s_req0 = 1'b1;
      n = 0;
      while (!s_gnt0 && n < 10) begin @(negedge clk); n++; end
      chk("w1_gnt_latency", 65'(n), 65'd1);
      chk("w1_busy", {64'd0, s_busy}, 65'd1);
      s_req0 = 1'b0;
      @(negedge clk);
      chk("w1_done_next", {64'd0, s_done}, 65'd1);
      chk("w1_busy_done", {64'd0, s_busy}, 65'd0);
      chk("w1_sum", {49'd0, s_sum}, {49'd0, e[15:0]});
      chk("w1_cout", {64'd0, s_cout}, {64'd0, e[16]});
   endtask

   initial begin
      req0 = 0; req1 = 0; cin0 = 0; cin1 = 0; sub0 = 0; sub1 = 0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      s_req0 = 0; s_req1 = 0; s_cin0 = 0; s_cin1 = 0; s_sub0 = 0; s_sub1 = 0;
      s_a0 = '0; s_b0 = '0; s_a1 = '0; s_b1 = '0;
      repeat (2) @(negedge clk);
      chk("rst_gnt", {63'd0, gnt0, gnt1}, 65'd0);
      chk("rst_busy_done", {62'd0, busy, done, done_id}, 65'd0);
      chk("rst_sum_cout", {cout, sum}, 65'd0);
      chk("rst_w1", {46'd0, s_gnt0, s_busy, s_done, s_cout, s_sum}, 65'd0);
      rst_n = 1'b1;

      // carry ripples through all four slices
      op4(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
      chk("ripple_sum_zero", {cout, sum}, {1'b1, 64'd0});
      // carry crosses one slice boundary via cin
      op4(1'b1, 64'h0000_0000_0000_FFFF, 64'd0, 1'b1, 1'b0);
      chk("interslice", {cout, sum}, {1'b0, 64'h0000_0000_0001_0000});

      // round-robin with both requesters held: 0,1,0, WORDS+1 apart
      do_reset();
      begin : arb_blk
         int cyc, ng, nd, prev_g;
         logic g, re0;
         logic [64:0] q_exp[$];
         logic q_id[$];
         logic [64:0] e;
         cyc = 0; ng = 0; nd = 0; prev_g = 0; re0 = 1'b0;
         @(negedge clk);
         a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom}; cin0 = 1'($urandom_range(0, 1));
         a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom}; cin1 = 1'($urandom_range(0, 1));
         sub0 = 1'b0; sub1 = 1'b0;
         req0 = 1'b1; req1 = 1'b1;
         while (nd < 3 && cyc < 100) begin
            @(negedge clk); cyc++;
            if (re0) begin
               a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
               req0 = 1'b1; re0 = 1'b0;
            end
            if (gnt0 | gnt1) begin
               g = gnt1;
               chk("arb_onehot", {64'd0, gnt0 & gnt1}, 65'd0);
               chk("arb_order", {64'd0, g}, 65'(ng % 2));
               if (ng > 0) chk("arb_gap", 65'(cyc - prev_g), 65'd5);
               prev_g = cyc;
               e = g ? ref_add(a1, b1, cin1, 1'b0, 4) : ref_add(a0, b0, cin0, 1'b0, 4);
               q_exp.push_back(e);
               q_id.push_back(g);
               if (g) req1 = 1'b0; else req0 = 1'b0;
               if (ng == 0) re0 = 1'b1;
               ng++;
            end
            if (done) begin
               if (q_exp.size() == 0) begin
                  chk("arb_spurious_done", 65'd1, 65'd0);
               end else begin
                  e = q_exp.pop_front();
                  chk("arb_done_id", {64'd0, done_id}, {64'd0, q_id.pop_front()});
                  chk("arb_result", {cout, sum}, e);
               end
               nd++;
            end
         end
         chk("arb_done_count", 65'(nd), 65'd3);
         req0 = 1'b0; req1 = 1'b0;
      end

      // reset while k=2: outputs clear at once, no done for the aborted op
      begin : rst_blk
         int n, nd;
         @(negedge clk);
         a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom}; req0 = 1'b1;
         n = 0;
         while (!gnt0 && n < 10) begin @(negedge clk); n++; end
         chk("mid_gnt", {64'd0, gnt0}, 65'd1);
         req0 = 1'b0;
         repeat (2) @(negedge clk);
         chk("mid_busy_before", {64'd0, busy}, 65'd1);
         rst_n = 1'b0;
         #1;
         chk("mid_rst_ctrl", {60'd0, gnt0, gnt1, busy, done, done_id}, 65'd0);
         chk("mid_rst_data", {cout, sum}, 65'd0);
         @(negedge clk);
         rst_n = 1'b1;
         nd = 0;
         repeat (10) begin @(negedge clk); if (done | busy) nd++; end
         chk("mid_no_done", 65'(nd), 65'd0);
      end
      op4(1'b0, 64'd3, 64'd4, 1'b0, 1'b0);
      chk("after_rst_sum", {cout, sum}, {1'b0, 64'd7});

`ifdef ADDSEQ_SUB_EN
      op4(1'b0, 64'd5, 64'd7, 1'b0, 1'b1);
      chk("sub_neg", {cout, sum}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
      op4(1'b0, 64'd7, 64'd5, 1'b0, 1'b1);
      chk("sub_pos", {cout, sum}, {1'b1, 64'd2});
`endif

      // WORDS=1: done directly follows gnt
      op1(16'h8000, 16'h8000, 1'b0, 1'b0);
      chk("w1_8000", {48'd0, s_cout, s_sum}, {48'd0, 1'b1, 16'd0});
      for (int i = 0; i < 4; i++)
         op1(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), rnd_sub());

      for (int i = 0; i < 8; i++)
         op4(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom_range(0, 1)), rnd_sub());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
